telemetry_uart_framer: RTL and testbench

Downstream consumer of the read-back byte stream produced by read_buffer in the SDRAM memory-test path. It pulls bytes over a valid/ready handshake and wraps each group of PAYLOAD_LEN bytes in a frame: sync word, sequence number, payload, then checksum. It serialises the frame as 8N1 UART on TX for the ground/debug link. This replaces the raw parallel DB0..DB7 output with a self-delimiting serial telemetry stream.

---
 rtl/telemetry_uart_framer.sv | 184 ++++++++++++++++++
 tb/tb_telemetry_uart_framer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_uart_framer.sv
`default_nettype none
// ============================================================================
// Module      : telemetry_uart_framer
// Description : Pulls payload bytes over a valid/ready handshake and frames
//               them as SYNC0, SYNC1, SEQ, payload, CSUM, sent as 8N1 UART.
// Revision    : 1.0 - initial release
// ============================================================================
module telemetry_uart_framer #(
    parameter int         CLKS_PER_BIT = 417,
    parameter int         PAYLOAD_LEN  = 20,
    parameter logic [7:0] SYNC0        = 8'hA5,
    parameter logic [7:0] SYNC1        = 8'h5A
) (
    input  logic        CLK_48MHZ,
    input  logic        RESET,
    input  logic [7:0]  BYTE_IN,
    input  logic        BYTE_VALID,
    output logic        BYTE_READY,
    output logic        TX,
    output logic        BUSY,
    output logic        FRAME_DONE,
    output logic [15:0] FRAME_COUNT
);

    localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]          c_PLEN      = 8'(PAYLOAD_LEN);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SYNC_A  = 3'd1;
    localparam logic [2:0] c_ST_SYNC_B  = 3'd2;
    localparam logic [2:0] c_ST_SEQ     = 3'd3;
    localparam logic [2:0] c_ST_PAYLOAD = 3'd4;
    localparam logic [2:0] c_ST_CSUM    = 3'd5;

    logic [2:0]          r_state;
    logic [9:0]          r_shift;      // {stop, data[7:0], start}, shifted out LSB first
    logic [c_BAUD_W-1:0] r_baud;
    logic [3:0]          r_bit;
    logic                r_active;
    logic                r_busy;
    logic                r_done;
    logic [15:0]         r_frame_count;
    logic [7:0]          r_seq;
    logic [7:0]          r_csum;
    logic [7:0]          r_pay_cnt;

    logic                w_byte_end;
    logic                w_ready;
    logic                w_hs;
    logic                w_load;
    logic [7:0]          w_load_byte;

    // Final cycle of the current byte's stop bit.
    assign w_byte_end = r_active && (r_bit == 4'd9) && (r_baud == c_BAUD_LAST);

    // The accept slot includes the final stop-bit cycle of the previous byte
    // (SEQ or a payload byte) so a waiting byte follows with no idle gap.
    assign w_ready = ((r_state == c_ST_SEQ) && w_byte_end) ||
                     ((r_state == c_ST_PAYLOAD) && (r_pay_cnt != c_PLEN) &&
                      (!r_active || w_byte_end));
    assign w_hs    = w_ready && BYTE_VALID;

    // Select the next byte to hand to the serialiser, if any.
    always_comb begin
        w_load      = 1'b0;
        w_load_byte = 8'h00;
        case (r_state)
            c_ST_IDLE: begin
                if (BYTE_VALID) begin
                    w_load      = 1'b1;
                    w_load_byte = SYNC0;
                end
            end
            c_ST_SYNC_A: begin
                if (w_byte_end) begin
                    w_load      = 1'b1;
                    w_load_byte = SYNC1;
                end
            end
            c_ST_SYNC_B: begin
                if (w_byte_end) begin
                    w_load      = 1'b1;
                    w_load_byte = r_seq;
                end
            end
            c_ST_SEQ, c_ST_PAYLOAD: begin
                if (w_hs) begin
                    w_load      = 1'b1;
                    w_load_byte = BYTE_IN;
                end else if ((r_state == c_ST_PAYLOAD) && w_byte_end && (r_pay_cnt == c_PLEN)) begin
                    w_load      = 1'b1;
                    w_load_byte = r_csum;
                end
            end
            default: begin
                w_load      = 1'b0;
                w_load_byte = 8'h00;
            end
        endcase
    end

    // 8N1 serialiser: bit timing, shift-out and back-to-back reload.
    always_ff @(posedge CLK_48MHZ) begin
        if (!RESET) begin
            r_shift  <= 10'h3FF;
            r_baud   <= '0;
            r_bit    <= 4'd0;
            r_active <= 1'b0;
        end else begin
            if (r_active) begin
                if (r_baud == c_BAUD_LAST) begin
                    r_baud  <= '0;
                    r_shift <= {1'b1, r_shift[9:1]};
                    if (r_bit == 4'd9) begin
                        r_bit    <= 4'd0;
                        r_active <= 1'b0;
                    end else begin
                        r_bit <= r_bit + 4'd1;
                    end
                end else begin
                    r_baud <= r_baud + c_BAUD_W'(1);
                end
            end
            if (w_load) begin
                r_shift  <= {1'b1, w_load_byte, 1'b0};
                r_baud   <= '0;
                r_bit    <= 4'd0;
                r_active <= 1'b1;
            end
        end
    end

    // Frame sequencing, checksum accumulation and frame bookkeeping.
    always_ff @(posedge CLK_48MHZ) begin
        if (!RESET) begin
            r_state       <= c_ST_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_frame_count <= 16'h0000;
            r_seq         <= 8'h00;
            r_csum        <= 8'h00;
            r_pay_cnt     <= 8'h00;
        end else begin
            r_done <= 1'b0;
            if (w_hs) begin
                r_csum    <= r_csum + BYTE_IN;
                r_pay_cnt <= r_pay_cnt + 8'd1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (BYTE_VALID) begin
                        r_state   <= c_ST_SYNC_A;
                        r_busy    <= 1'b1;
                        r_seq     <= r_frame_count[7:0];
                        r_csum    <= r_frame_count[7:0];
                        r_pay_cnt <= 8'h00;
                    end
                end
                c_ST_SYNC_A:  if (w_byte_end) r_state <= c_ST_SYNC_B;
                c_ST_SYNC_B:  if (w_byte_end) r_state <= c_ST_SEQ;
                c_ST_SEQ:     if (w_byte_end) r_state <= c_ST_PAYLOAD;
                c_ST_PAYLOAD: if (w_byte_end && (r_pay_cnt == c_PLEN)) r_state <= c_ST_CSUM;
                c_ST_CSUM: begin
                    if (w_byte_end) begin
                        r_state       <= c_ST_IDLE;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_frame_count <= r_frame_count + 16'd1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign BYTE_READY  = w_ready;
    assign TX          = r_active ? r_shift[0] : 1'b1;
    assign BUSY        = r_busy;
    assign FRAME_DONE  = r_done;
    assign FRAME_COUNT = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_telemetry_uart_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_telemetry_uart_framer
// Description : Directed, table-driven bench for telemetry_uart_framer with
//               a UART receive monitor on TX.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_telemetry_uart_framer;

    localparam int c_CPB  = 4;
    localparam int c_PLEN = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    telemetry_uart_framer #(
        .CLKS_PER_BIT(c_CPB),
        .PAYLOAD_LEN (c_PLEN),
        .SYNC0       (8'hA5),
        .SYNC1       (8'h5A)
    ) dut (
        .CLK_48MHZ  (clk),
        .RESET      (rst_n),
        .BYTE_IN    (byte_in),
        .BYTE_VALID (byte_valid),
        .BYTE_READY (byte_ready),
        .TX         (tx),
        .BUSY       (busy),
        .FRAME_DONE (frame_done),
        .FRAME_COUNT(frame_count)
    );

    always #5 clk = ~clk;

    // UART receive monitor: samples mid-bit on the falling edge.
    logic [7:0] rx_q[$];
    int         m_off = 0;
    logic       m_busy = 1'b0;
    logic [7:0] m_sh = 8'h00;
    int         stop_errs = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_off  <= 0;
        end else if (!m_busy) begin
            if (tx == 1'b0) begin
                m_busy <= 1'b1;
                m_off  <= 1;
            end
        end else begin
            if (m_off >= 6 && m_off <= 34 && (m_off % 4) == 2)
                m_sh <= {tx, m_sh[7:1]};
            if (m_off == 38) begin
                rx_q.push_back(m_sh);
                if (tx != 1'b1) stop_errs <= stop_errs + 1;
            end
            if (m_off == 39) m_busy <= 1'b0;
            m_off <= m_off + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_q.delete();
    endtask

    function automatic logic [7:0] pay_byte(input logic [23:0] pay, input int idx);
        if (idx >= 0 && idx < c_PLEN) return pay[23 - 8*idx -: 8];
        return 8'h00;
    endfunction

    // Runs one frame with BYTE_VALID held high (optionally stalling after P[0]);
    // returns the cycle of FRAME_DONE relative to the first valid cycle.
    task automatic run_frame(input logic [23:0] pay, input int stall,
                             output int done_cyc, output int hs_cnt);
        int   cyc = 0;
        int   idx = 0;
        int   stall_start = -100;
        int   resume_cyc  = -100;
        int   stall_bad   = 0;
        logic hs;
        logic done = 1'b0;
        hs_cnt   = 0;
        done_cyc = -1;
        byte_in    = pay_byte(pay, 0);
        byte_valid = 1'b1;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            hs = byte_valid && byte_ready;
            if (hs) hs_cnt++;
            if (stall > 0 && cyc >= stall_start && cyc < resume_cyc)
                if (!(tx && busy && byte_ready)) stall_bad++;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                idx++;
                byte_in = pay_byte(pay, idx);
                if (stall > 0 && idx == 1) begin
                    byte_valid  = 1'b0;
                    stall_start = cyc + 40;
                    resume_cyc  = cyc + 40 + stall;
                end
            end
            if (stall > 0 && cyc == resume_cyc) byte_valid = 1'b1;
            if (stall > 0 && cyc == resume_cyc + 1) begin
                chk("stall_resume_start_bit", int'(tx), 0);
                chk("stall_resume_ready_low", int'(byte_ready), 0);
            end
            if (frame_done) begin
                done     = 1'b1;
                done_cyc = cyc;
                byte_valid = 1'b0;
            end
        end
        if (!done) chk("frame_timeout", 0, 1);
        if (stall > 0) chk("stall_hold_bad_cycles", stall_bad, 0);
    endtask

    task automatic check_frame(input logic [7:0] seq, input logic [23:0] pay,
                               input logic [7:0] csum);
        logic [7:0] exp[7];
        exp[0] = 8'hA5; exp[1] = 8'h5A; exp[2] = seq;
        exp[3] = pay_byte(pay, 0); exp[4] = pay_byte(pay, 1); exp[5] = pay_byte(pay, 2);
        exp[6] = csum;
        chk("rx_byte_count", rx_q.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < rx_q.size()) chk($sformatf("rx_byte%0d", i), int'(rx_q[i]), int'(exp[i]));
        chk("stop_bit_errors", stop_errs, 0);
        rx_q.delete();
    endtask

    typedef struct {
        logic        do_reset;
        logic        preload;
        logic [23:0] pay;
        logic [7:0]  seq;
        logic [7:0]  csum;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int done_cyc;
        int hs_cnt;
        int hs2;
        int done_seen;

        vecs[0] = '{1'b1, 1'b0, 24'h010203, 8'h00, 8'h06, 16'h0001};
        vecs[1] = '{1'b0, 1'b0, 24'h010203, 8'h01, 8'h07, 16'h0002};
        vecs[2] = '{1'b1, 1'b0, 24'hFFFFFF, 8'h00, 8'hFD, 16'h0001};
        vecs[3] = '{1'b0, 1'b1, 24'h010203, 8'hFF, 8'h05, 16'h0000};

        reset_dut();
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ready", int'(byte_ready), 0);
        chk("reset_done", int'(frame_done), 0);
        chk("reset_count", int'(frame_count), 0);

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].do_reset) reset_dut();
            if (vecs[v].preload) begin
                force dut.r_frame_count = 16'hFFFF;
                #2;
                release dut.r_frame_count;
                #1;
                chk("preload_count", int'(frame_count), 16'hFFFF);
            end
            repeat (3) @(posedge clk);
            #1;
            run_frame(vecs[v].pay, 0, done_cyc, hs_cnt);
            chk($sformatf("v%0d_done_latency", v), done_cyc, 10 * c_CPB * (c_PLEN + 4) + 1);
            chk($sformatf("v%0d_handshakes", v), hs_cnt, c_PLEN);
            chk($sformatf("v%0d_frame_count", v), int'(frame_count), int'(vecs[v].cnt));
            chk($sformatf("v%0d_busy_at_done", v), int'(busy), 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_one_cycle", v), int'(frame_done), 0);
            repeat (5) @(posedge clk);
            #1;
            check_frame(vecs[v].seq, vecs[v].pay, vecs[v].csum);
        end

        // Stall for 50 cycles between P[0] and P[1].
        reset_dut();
        repeat (3) @(posedge clk);
        #1;
        run_frame(24'h010203, 50, done_cyc, hs_cnt);
        chk("stall_done_latency", done_cyc, 10 * c_CPB * (c_PLEN + 4) + 1 + 51);
        chk("stall_handshakes", hs_cnt, c_PLEN);
        repeat (5) @(posedge clk);
        #1;
        check_frame(8'h00, 24'h010203, 8'h06);

        // Reset pulse in the middle of P[1] data bits.
        reset_dut();
        byte_in = 8'h01;
        byte_valid = 1'b1;
        hs2 = 0;
        done_seen = 0;
        for (int c = 0; c < 1000 && hs2 < 2; c++) begin
            @(negedge clk);
            if (byte_valid && byte_ready) hs2++;
            if (frame_done) done_seen++;
            @(posedge clk); #1;
            if (hs2 == 1) byte_in = 8'h02;
        end
        chk("midreset_reached_p1", hs2, 2);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        byte_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset_tx", int'(tx), 1);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_ready", int'(byte_ready), 0);
        chk("midreset_count", int'(frame_count), 0);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (frame_done) done_seen++;
        end
        chk("midreset_no_done", done_seen, 0);
        rx_q.delete();
        @(posedge clk); #1;
        run_frame(24'h010203, 0, done_cyc, hs_cnt);
        chk("postreset_done_latency", done_cyc, 10 * c_CPB * (c_PLEN + 4) + 1);
        chk("postreset_count", int'(frame_count), 1);
        repeat (5) @(posedge clk);
        #1;
        check_frame(8'h00, 24'h010203, 8'h06);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
